// File: rtl/saber_msg_decode.sv
// saber_msg_decode: Saber decryption message recovery.
// Unpacks ET-bit op terms, rounds v against them, packs message bits.
module saber_msg_decode #(
  parameter int ET = 4,
  parameter int EP = 10,
  parameter int EQ = 13,
  parameter int H2 = 2**(EP-2) - 2**(EP-ET-1) + 2**(EQ-EP-1),
  parameter int N  = 256,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          read_sel,
  output logic [AW-1:0] read_address,
  input  logic [63:0]   read_data,
  output logic [AW-1:0] write_address,
  output logic [63:0]   write_data,
  output logic          write_en,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OP_REQ  = 3'd1;
  localparam logic [2:0] S_OP_LOAD = 3'd2;
  localparam logic [2:0] S_V_REQ   = 3'd3;
  localparam logic [2:0] S_V_LOAD  = 3'd4;
  localparam logic [2:0] S_COMPUTE = 3'd5;
  localparam logic [2:0] S_STORE   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam int            GW     = 4 * ET;
  localparam logic [6:0]    GW7    = 7'(GW);
  localparam logic [EP-1:0] H2C    = EP'(H2);
  localparam logic [AW-1:0] V_LAST = AW'(N / 4);

  logic [2:0]         state;
  logic [AW-1:0]      op_addr;
  logic [AW-1:0]      v_addr;
  logic [6:0]         fill;
  logic [3:0]         grp;
  logic [127:0]       opbuf;
  logic [3:0][EP-1:0] vbuf;
  logic [63:0]        m_buffer;

  logic [3:0][EP-1:0] opk;
  logic [3:0][EP-1:0] sum;
  logic [3:0]         bits;
  logic [6:0]         fill_less;

  // Each lane subtracts the scaled op term mod 2^EP and keeps the MSB.
  always_comb begin
    opk  = '0;
    sum  = '0;
    bits = '0;
    for (int k = 0; k < 4; k++) begin
      opk[k]  = {opbuf[k*ET +: ET], {(EP-ET){1'b0}}};
      sum[k]  = vbuf[k] + H2C - opk[k];
      bits[k] = sum[k][EP-1];
    end
  end

  assign fill_less = fill - GW7;

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign write_en   = (state == S_STORE);
  assign write_data = m_buffer;
  assign read_sel   = (state == S_OP_REQ);

  always_comb begin
    read_address = '0;
    if (state == S_OP_REQ)
      read_address = op_addr;
    else if (state == S_V_REQ)
      read_address = v_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_addr       <= '0;
      v_addr        <= '0;
      write_address <= '0;
      fill          <= '0;
      grp           <= '0;
      opbuf         <= '0;
      vbuf          <= '0;
      m_buffer      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_OP_REQ;
            op_addr       <= '0;
            v_addr        <= '0;
            write_address <= '0;
            fill          <= '0;
            grp           <= '0;
            opbuf         <= '0;
            m_buffer      <= '0;
          end
        end
        S_OP_REQ: state <= S_OP_LOAD;
        S_OP_LOAD: begin
          opbuf   <= opbuf | ({64'd0, read_data} << fill);
          fill    <= fill + 7'd64;
          op_addr <= op_addr + 1'b1;
          state   <= S_V_REQ;
        end
        S_V_REQ: state <= S_V_LOAD;
        S_V_LOAD: begin
          for (int k = 0; k < 4; k++)
            vbuf[k] <= read_data[16*k +: EP];
          v_addr <= v_addr + 1'b1;
          state  <= S_COMPUTE;
        end
        S_COMPUTE: begin
          m_buffer <= {bits, m_buffer[63:4]};
          opbuf    <= opbuf >> GW;
          fill     <= fill_less;
          grp      <= grp + 1'b1;
          if (grp == 4'hF)
            state <= S_STORE;
          else if (fill_less < GW7)
            state <= S_OP_REQ;
          else
            state <= S_V_REQ;
        end
        S_STORE: begin
          write_address <= write_address + 1'b1;
          if (v_addr == V_LAST)
            state <= S_DONE;
          else if (fill < GW7)
            state <= S_OP_REQ;
          else
            state <= S_V_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saber_msg_decode.sv
// tb_saber_msg_decode: three instances (ET=4,3,6) against a
// coefficient-level rounding model of message recovery.
module tb_saber_msg_decode;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic          read_sel      [3];
  logic [AW-1:0] read_address  [3];
  logic [63:0]   read_data     [3];
  logic [AW-1:0] write_address [3];
  logic [63:0]   write_data    [3];
  logic          write_en      [3];
  logic          busy          [3];
  logic          done          [3];

  logic [63:0] v_mem  [64];
  logic [63:0] op_mem [3][24];
  logic [63:0] exp_w  [3][4];
  logic [63:0] wd_log [3][4];

  int checks = 0;
  int errors = 0;
  int opcnt [3];
  int wcnt  [3];
  int lat   [3];

  always #5 clk = ~clk;

  saber_msg_decode #(.ET(4)) u_et4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .read_sel(read_sel[0]), .read_address(read_address[0]),
    .read_data(read_data[0]), .write_address(write_address[0]),
    .write_data(write_data[0]), .write_en(write_en[0]),
    .busy(busy[0]), .done(done[0])
  );

  saber_msg_decode #(.ET(3)) u_et3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .read_sel(read_sel[1]), .read_address(read_address[1]),
    .read_data(read_data[1]), .write_address(write_address[1]),
    .write_data(write_data[1]), .write_en(write_en[1]),
    .busy(busy[1]), .done(done[1])
  );

  saber_msg_decode #(.ET(6)) u_et6 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .read_sel(read_sel[2]), .read_address(read_address[2]),
    .read_data(read_data[2]), .write_address(write_address[2]),
    .write_data(write_data[2]), .write_en(write_en[2]),
    .busy(busy[2]), .done(done[2])
  );

  // Synchronous memories, one cycle of read latency.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (read_sel[d])
        read_data[d] <= (int'(read_address[d]) < 24) ?
          op_mem[d][int'(read_address[d])] : 64'hBAD0BAD0BAD0BAD0;
      else
        read_data[d] <= (int'(read_address[d]) < 64) ?
          v_mem[int'(read_address[d])] : 64'hBAD1BAD1BAD1BAD1;
    end
  end

  function automatic int et_of(int d);
    return (d == 0) ? 4 : ((d == 1) ? 3 : 6);
  endfunction

  function automatic int h2_of(int et);
    return 256 - (1 << (9 - et)) + 4;
  endfunction

  function automatic bit model_bit(int et, int v, int op);
    int s;
    s = v + h2_of(et) - op * (1 << (10 - et));
    s = ((s % 1024) + 1024) % 1024;
    return s >= 512;
  endfunction

  function automatic int op_coef(int d, int i);
    int r;
    int p;
    r = 0;
    for (int b = 0; b < et_of(d); b++) begin
      p = i * et_of(d) + b;
      if (op_mem[d][p / 64][p % 64])
        r = r + (1 << b);
    end
    return r;
  endfunction

  function automatic int v_coef(int i);
    logic [63:0] w;
    w = v_mem[i / 4];
    return int'(w[16 * (i % 4) +: 10]);
  endfunction

  task automatic build_exp();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < 64; j++)
          exp_w[d][w][j] = model_bit(et_of(d), v_coef(64*w + j),
                                     op_coef(d, 64*w + j));
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, req);
    end
  endtask

  task automatic fill_const(input int vv, input logic [63:0] opw);
    for (int i = 0; i < 64; i++)
      v_mem[i] = {4{16'(vv)}};
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 24; i++)
        op_mem[d][i] = opw;
    build_exp();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++)
      v_mem[i] = {$urandom, $urandom};
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 24; i++)
        op_mem[d][i] = {$urandom, $urandom};
    build_exp();
  endtask

  task automatic check_zero_outs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ctl%0d", tag, d),
            {60'd0, busy[d], done[d], write_en[d], read_sel[d]}, 64'd0);
      check($sformatf("%s_addr%0d", tag, d),
            {46'd0, read_address[d], write_address[d]}, 64'd0);
      check($sformatf("%s_wd%0d", tag, d), write_data[d], 64'd0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          if (write_en[d]) begin
            check($sformatf("wr_addr%0d", d), 64'(write_address[d]),
                  64'(wcnt[d]));
            check($sformatf("wr_data%0d_w%0d", d, wcnt[d]), write_data[d],
                  exp_w[d][wcnt[d] & 3]);
            if (wcnt[d] < 4)
              wd_log[d][wcnt[d]] = write_data[d];
            wcnt[d]++;
          end
          if (busy[d] && read_sel[d]) begin
            check($sformatf("op_rd_addr%0d", d), 64'(read_address[d]),
                  64'(opcnt[d]));
            opcnt[d]++;
          end
        end
      end
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      opcnt[d] = 0;
      wcnt[d] = 0;
      lat[d] = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input bit poke);
    int n;
    clear_counts();
    pulse_start();
    n = 0;
    while (!(lat[0] != 0 && lat[1] != 0 && lat[2] != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 40) start = 1'b1;
      if (poke && n == 41) start = 1'b0;
      for (int d = 0; d < 3; d++)
        if (done[d] && lat[d] == 0) lat[d] = n;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("latency%0d", d), 64'(lat[d]),
            64'(192 + 8 * et_of(d) + 4));
      check($sformatf("writes%0d", d), 64'(wcnt[d]), 64'd4);
      check($sformatf("op_words%0d", d), 64'(opcnt[d]), 64'(4 * et_of(d)));
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("done_hold%0d", d), {62'd0, busy[d], done[d]}, 64'd1);
  endtask

  task automatic abort_job();
    int seen;
    int n;
    clear_counts();
    pulse_start();
    seen = 0;
    n = 0;
    while (seen < 2 && n < 400) begin
      @(negedge clk);
      n++;
      if (write_en[0]) seen++;
    end
    check("abort_reach", 64'(seen), 64'd2);
    rst_n = 1'b0;
    #1;
    check_zero_outs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero_outs("idle_hold");
  endtask

  initial begin
    logic [63:0] t;
    clear_counts();
    fill_const(0, 64'd0);
    fork
      monitor();
    join_none
    #1;
    check_zero_outs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("h2_et4", 64'(h2_of(4)), 64'd228);
    check("h2_et3", 64'(h2_of(3)), 64'd196);
    check("h2_et6", 64'(h2_of(6)), 64'd252);
    check("pin_v0_op0", 64'(model_bit(4, 0, 0)), 64'd0);
    check("pin_v3ff_op0", 64'(model_bit(4, 1023, 0)), 64'd0);
    check("pin_v300_op0", 64'(model_bit(4, 300, 0)), 64'd1);
    check("pin_v0_op15", 64'(model_bit(4, 0, 15)), 64'd0);
    check("pin_v300_op15", 64'(model_bit(4, 300, 15)), 64'd1);

    fill_const(0, 64'd0);
    run_job(1'b0);
    check("zero_word", wd_log[0][3], 64'd0);

    fill_const(1023, 64'd0);
    run_job(1'b0);
    check("v3ff_word", wd_log[0][2], 64'd0);

    fill_const(300, 64'd0);
    run_job(1'b0);
    check("v300_word", wd_log[0][1], 64'hFFFFFFFFFFFFFFFF);

    fill_const(0, 64'hFFFFFFFFFFFFFFFF);
    run_job(1'b0);
    check("wrap_v0_word", wd_log[0][0], 64'd0);

    fill_const(300, 64'hFFFFFFFFFFFFFFFF);
    run_job(1'b0);
    check("wrap_v300_word", wd_log[0][3], 64'hFFFFFFFFFFFFFFFF);

    // ET=6 coefficient 10 spans op words 0 and 1; op=33, v=800 -> bit 1.
    fill_rand();
    t = op_mem[2][0];
    t[63:60] = 4'b0001;
    op_mem[2][0] = t;
    t = op_mem[2][1];
    t[1:0] = 2'b10;
    op_mem[2][1] = t;
    t = v_mem[2];
    t[41:32] = 10'd800;
    v_mem[2] = t;
    build_exp();
    run_job(1'b0);
    check("straddle_coef", 64'(wd_log[2][0][10]), 64'd1);

    fill_rand();
    run_job(1'b1);
    fill_rand();
    run_job(1'b0);

    fill_rand();
    abort_job();
    run_job(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saber_msg_decode.md
# saber_msg_decode

Parametrised message-recovery engine for the Saber decryption path, covering LightSaber, Saber and FireSaber. It streams the packed ciphertext term `op` (ET bits per coefficient, densely bit-packed) and the polynomial `v` (four EP-bit coefficients per 64-bit word) from the coprocessor data memory. For every coefficient it computes `m[i] = ((v[i] + H2 - (op[i] << (EP-ET))) mod 2^EP) >> (EP-1)` and writes the N-bit message back as 64-bit words. Compared with the fixed 4-bit unpacker it adds a selectable ET, a bit-stream unpacker that handles coefficients straddling word boundaries, and a start/busy/done handshake that allows restart.

## Interface
- ET, 4, ciphertext coefficient width; legal values are 3, 4, 6.
- EP, 10, rounding modulus exponent p = 2^EP.
- EQ, 13, modulus exponent q = 2^EQ.
- H2, 2^(EP-2) - 2^(EP-ET-1) + 2^(EQ-EP-1), rounding constant (228 for the defaults).
- N, 256, number of coefficients.
- AW, 9, memory address width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start pulse; accepted only in IDLE or DONE.
- read_sel  out  1  0 selects the v region, 1 selects the op region.
- read_address  out  AW  word index within the selected region.
- read_data  in  64  synchronous memory data, valid one cycle after the address.
- write_address  out  AW  message word index.
- write_data  out  64  message word.
- write_en  out  1  write strobe, one cycle per word.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE; held until the next start.

## Operation
- FSM states: IDLE, OP_REQ, OP_LOAD, V_REQ, V_LOAD, COMPUTE, STORE, DONE. Each state lasts exactly one cycle, except IDLE and DONE, which wait.
- Start:
  - IDLE/DONE with start=1 goes to OP_REQ.
  - v_addr, op_addr, write_address, fill and grp are cleared.
  - opbuf and m_buffer are cleared.
  - start is ignored while busy.
- OP_REQ: read_sel=1, read_address=op_addr.
- OP_LOAD: opbuf |= read_data << fill; fill += 64; op_addr++. Next state is V_REQ.
- V_REQ: read_sel=0, read_address=v_addr.
- V_LOAD: v_buffer <= read_data; v_addr++. Next state is COMPUTE.
- COMPUTE, for lanes k = 0..3:
  - vk = v_buffer[16k +: EP]; opk = opbuf[k*ET +: ET].
  - sum_k = vk + H2 - (opk << (EP-ET)), computed in EP bits with wrap-around modulo 2^EP.
  - bit_k = sum_k[EP-1].
  - m_buffer <= {bit3, bit2, bit1, bit0, m_buffer[63:4]}.
  - opbuf >>= 4*ET; fill -= 4*ET; grp++ (mod 16).
- After COMPUTE:
  - if grp wraps to 0, go to STORE;
  - else if fill < 4*ET, go to OP_REQ;
  - else go to V_REQ.
- STORE: write_en=1, write_data=m_buffer, then write_address++.
  - If v_addr == N/4, go to DONE.
  - Else if fill < 4*ET, go to OP_REQ; otherwise go to V_REQ.
- Bit order: coefficient 64w+j maps to message word w, bit j.
- opbuf is 128 bits and fill is 7 bits. Maximum occupancy is 4*ET - 1 + 64 = 87 bits, so it never overflows.
- Reset mid-operation: asynchronously returns to IDLE with all registers zero. Memory contents already written are not rolled back.

## Timing
- Reset values: read_sel=0, read_address=0, write_address=0, write_data=0, write_en=0, busy=0, done=0.
- read_address and read_sel are decoded from the state register. Data is captured on the edge that ends the following state.
- Op words consumed: N*ET/64 (12, 16 or 24 for N=256 and ET=3, 4, 6). No word is fetched beyond that count.
- Latency: done rises 3*(N/4) + 2*(N*ET/64) + N/64 cycles after the edge that samples start. For N=256 this is 220 (ET=3), 228 (ET=4) or 244 (ET=6).
- write_en pulses exactly N/64 times, at write_address 0..N/64-1.
- Restart from DONE reuses the same sequence with identical latency.

## Test plan
- ET=4, N=256, all v=0 and all op=0: sum=228 < 512, so all four message words are 0x0000000000000000 and done rises at cycle 228.
- ET=4, all v=0x3FF and all op=0: sum = 1251 mod 1024 = 227, so all message words are 0. With v=300 and op=0, sum=528, bit=1, so all words are 0xFFFFFFFFFFFFFFFF.
- ET=3, reference vectors produced by a software model from a random seed: write_data matches bit-exactly, op words read are exactly 0..11, and done rises at cycle 220.
- ET=6, with op coefficient 10 straddling the 64/128 bit boundary: the straddling coefficient decodes correctly, op words read are 0..23, and done rises at cycle 244.
- Wrap-around: v=0, op=15, ET=4 gives sum = (228 - 960) mod 1024 = 292, so bit=0. With v=300 and op=15, sum=592, so bit=1.
- Deassert rst_n during the second STORE: outputs are zero immediately and the FSM stays in IDLE. A following start re-runs the full job and produces correct data; a start pulsed while busy is ignored.
